lcd_cmd_seq: RTL and testbench
==============================

Name: lcd_cmd_seq

Overview:
- Script-driven command source that sits directly upstream of the LCD image controller.
- Reads a 4-bit command script from a command ROM and issues one command at a time on the controller's cmd/cmd_valid interface.
- Respects the controller's busy during image load and always terminates with a WRITE (cmd 0).
- Then waits for the controller's done and reports completion; used as the stimulus/bring-up driver in the LCD subsystem.

Parameters:
- AW, 5, command ROM address width; script depth is 2^AW entries.
- CMD_W, 4, command code width; must match the controller.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- start  input  1  one-cycle pulse; begins script execution from address 0.
- CROM_rd  output  1  command ROM read enable.
- CROM_A  output  AW  command ROM address.
- CROM_Q  input  CMD_W  command ROM data, valid the cycle after CROM_rd=1.
- busy  input  1  controller busy; commands may only be issued when 0.
- done  input  1  controller done; write-back complete.
- cmd  output  CMD_W  command to controller.
- cmd_valid  output  1  one-cycle command strobe.
- finished  output  1  high from done observed until next start.
- err  output  1  sticky: invalid code skipped or script ran off end.
- issued_cnt  output  AW+1  number of commands issued since start (saturating at 2^(AW+1)-1).

Behaviour:
- Reset (reset=0 at clk edge):
  - State goes to IDLE.
  - ptr=0; outputs cmd=0, cmd_valid=0, CROM_rd=0, CROM_A=0, finished=0, err=0, issued_cnt=0.
  - Reset mid-script aborts immediately, with no further cmd_valid.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, FIN.
- IDLE: start=1 -> FETCH; ptr=0, err=0, issued_cnt=0, finished=0.
- FETCH: CROM_rd=1, CROM_A=ptr for exactly one cycle -> LATCH.
- LATCH: CROM_Q registered into cmd_r.
  - Code 12..15: invalid. Set err, do not issue. If ptr=2^AW-1 go to ISSUE with forced cmd_r=0; otherwise ptr+1 -> FETCH.
  - Otherwise -> ISSUE.
- ISSUE: hold while busy=1 (cmd_valid=0). When busy=0: cmd_valid=1 for one cycle, cmd=cmd_r, issued_cnt+1.
  - If cmd_r=0 (WRITE) -> WAIT_DONE.
  - Else if ptr=2^AW-1: script exhausted without WRITE. Set err, load cmd_r=0, stay in ISSUE; a forced WRITE is issued next cycle.
  - Else ptr+1 -> FETCH.
- cmd holds its last value when cmd_valid=0; cmd_valid is never high two consecutive cycles except for the forced-WRITE case.
- Throughput: one command per 3 cycles when busy=0 (FETCH, LATCH, ISSUE).
- WAIT_DONE: no commands issued. done=1 -> FIN, finished=1 on the following cycle.
- FIN: finished stays 1. start=1 -> behaves as start from IDLE.
- start while in FETCH/LATCH/ISSUE/WAIT_DONE is ignored.
- busy=1 at start (controller still loading): first command stalls in ISSUE until busy falls. The first cmd_valid is no earlier than the cycle busy is sampled 0.
- done arriving before WAIT_DONE is ignored; only done sampled in WAIT_DONE counts.
- ptr wraps never: the sequence always ends by the last entry.

Test Plan:
- Basic script: ROM={4,1,5,0}, busy=0, pulse start -> cmd_valid pulses carry 4,1,5,0 at 3-cycle spacing. issued_cnt=4, then done pulse -> finished=1, err=0.
- Load stall: busy=1 for 70 cycles after start, ROM={7,0} -> first cmd_valid (cmd=7) occurs in the first cycle busy=0. No strobe earlier.
- Invalid code: ROM={13,2,0} -> only 2 and 0 issued, issued_cnt=2, err=1.
- Missing WRITE: 32 entries all =3 -> 32 strobes of cmd 3, then a forced cmd 0 on the next cycle. err=1, issued_cnt=33.
- Reset mid-script: assert reset=0 while in ISSUE -> next cycle cmd_valid=0, CROM_rd=0, finished=0, issued_cnt=0. A later start re-runs from address 0.
- Start ignored / early done: pulse start and done during execution of ROM={1,0} -> sequence unaffected, finished=1 only after done in WAIT_DONE.

Source files
------------

// File: rtl/lcd_cmd_seq_if.sv
// lcd_cmd_seq_if: command ROM bus plus LCD controller
// command handshake seen by the script sequencer.
interface lcd_cmd_seq_if #(
  parameter int AW    = 5,
  parameter int CMD_W = 4
);
  logic             CROM_rd;
  logic [AW-1:0]    CROM_A;
  logic [CMD_W-1:0] CROM_Q;
  logic             busy;
  logic             done;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;

  modport master (
    output CROM_rd, CROM_A, cmd, cmd_valid,
    input  CROM_Q, busy, done
  );

  modport slave (
    input  CROM_rd, CROM_A, cmd, cmd_valid,
    output CROM_Q, busy, done
  );
endinterface

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: walks a command ROM script and feeds the
// LCD controller one command at a time, ending on WRITE.
module lcd_cmd_seq #(
  parameter int AW    = 5,
  parameter int CMD_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  lcd_cmd_seq_if.master bus,
  output logic          finished,
  output logic          err,
  output logic [AW:0]   issued_cnt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] LATCH     = 3'd2;
  localparam logic [2:0] ISSUE     = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] FIN       = 3'd5;

  localparam logic [AW-1:0]    PTR_LAST = '1;
  localparam logic [AW:0]      CNT_MAX  = '1;
  localparam logic [CMD_W-1:0] CMD_WR   = '0;
  localparam logic [CMD_W-1:0] CMD_INV  = CMD_W'(12);

  logic [2:0]       state;
  logic [AW-1:0]    ptr;
  logic [CMD_W-1:0] cmd_r;
  logic [CMD_W-1:0] cmd_hold;
  logic             issue;

  // Strobe goes out the cycle busy is seen low; a reset
  // in progress suppresses it so an abort is immediate.
  assign issue = reset && (state == ISSUE) && !bus.busy;

  assign bus.cmd_valid = issue;
  assign bus.cmd       = issue ? cmd_r : cmd_hold;
  assign bus.CROM_rd   = (state == FETCH);
  assign bus.CROM_A    = ptr;

  // Script FSM: fetch, latch, issue, then wait for done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      cmd_r      <= '0;
      cmd_hold   <= '0;
      finished   <= 1'b0;
      err        <= 1'b0;
      issued_cnt <= '0;
    end else begin
      unique case (state)
        IDLE, FIN: begin
          if (start) begin
            ptr        <= '0;
            err        <= 1'b0;
            issued_cnt <= '0;
            finished   <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          state <= LATCH;
        end
        LATCH: begin
          cmd_r <= bus.CROM_Q;
          if (bus.CROM_Q >= CMD_INV) begin
            err <= 1'b1;
            if (ptr == PTR_LAST) begin
              cmd_r <= CMD_WR;
              state <= ISSUE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= FETCH;
            end
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.busy) begin
            cmd_hold <= cmd_r;
            if (issued_cnt != CNT_MAX)
              issued_cnt <= issued_cnt + 1'b1;
            if (cmd_r == CMD_WR) begin
              state <= WAIT_DONE;
            end else if (ptr == PTR_LAST) begin
              err   <= 1'b1;
              cmd_r <= CMD_WR;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= FETCH;
            end
          end
        end
        WAIT_DONE: begin
          if (bus.done) begin
            finished <= 1'b1;
            state    <= FIN;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: randomized and directed scripts checked
// against a script-level model of the command stream.
module tb_lcd_cmd_seq;

  localparam int AW    = 5;
  localparam int CMD_W = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          finished;
  logic          err;
  logic [AW:0]   issued_cnt;

  lcd_cmd_seq_if #(.AW(AW), .CMD_W(CMD_W)) bus();

  assign bus.busy = busy;
  assign bus.done = done;

  lcd_cmd_seq #(.AW(AW), .CMD_W(CMD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .finished   (finished),
    .err        (err),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  logic [CMD_W-1:0] rom [DEPTH];
  int               cyc = 0;
  int               viol = 0;
  int               passed = 0;
  int               total = 0;
  int               mon_cmd [$];
  int               mon_cyc [$];
  int               exp_q [$];
  bit               exp_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.CROM_rd) bus.CROM_Q <= rom[bus.CROM_A];

  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) begin
      mon_cmd.push_back(int'(bus.cmd));
      mon_cyc.push_back(cyc);
      if (busy) viol++;
    end
  end

  // Script-level model: skip codes >= 12, stop at WRITE,
  // append a forced WRITE if the script never has one.
  function automatic void build_exp();
    bit wr = 0;
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] >= 12) exp_err = 1;
      else begin
        exp_q.push_back(int'(rom[i]));
        if (rom[i] == 0) begin
          wr = 1;
          break;
        end
      end
    end
    if (!wr) begin
      exp_q.push_back(0);
      exp_err = 1;
    end
  endfunction

  function automatic int seq_bad();
    if (mon_cmd.size() != exp_q.size()) return 999;
    foreach (exp_q[i])
      if (mon_cmd[i] != exp_q[i]) return i;
    return -1;
  endfunction

  task automatic load_rom(input int vals [$]);
    for (int i = 0; i < DEPTH; i++)
      rom[i] = (i < vals.size()) ? 4'(vals[i]) : 4'd0;
  endtask

  task automatic pulse_start();
    mon_cmd.delete();
    mon_cyc.delete();
    viol = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done = 1;
    @(posedge clk); #1 done = 0;
    @(negedge clk); #1;
  endtask

  task automatic run_to_write(input int budget,
                              input bit rnd,
                              output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (rnd) busy = ($urandom_range(0, 2) == 0);
      @(negedge clk); #1;
      if (mon_cmd.size() > 0 && mon_cmd[$] == 0) ok = 1;
    end
    busy = 0;
  endtask

  task automatic test_reset();
    reset = 0; start = 0; busy = 0; done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (bus.cmd_valid !== 1'b0 || bus.CROM_rd !== 1'b0)
      $display("FAIL reset_strobes valid=%b rd=%b want 0 0",
               bus.cmd_valid, bus.CROM_rd);
    else passed++;
    total++;
    if (bus.cmd !== 4'd0 || bus.CROM_A !== 5'd0)
      $display("FAIL reset_bus cmd=%0d A=%0d want 0 0",
               bus.cmd, bus.CROM_A);
    else passed++;
    total++;
    if (finished !== 1'b0 || err !== 1'b0 || issued_cnt !== 6'd0)
      $display("FAIL reset_status fin=%b err=%b cnt=%0d want 0",
               finished, err, issued_cnt);
    else passed++;
    @(posedge clk); #1 reset = 1;
  endtask

  task automatic test_basic();
    bit ok;
    load_rom('{4, 1, 5, 0});
    build_exp();
    pulse_start();
    run_to_write(100, 0, ok);
    total++;
    if (!ok) $display("FAIL basic_timeout got %0d strobes",
                      mon_cmd.size());
    else passed++;
    total++;
    if (seq_bad() != -1)
      $display("FAIL basic_seq bad at %0d got %0d cmds want 4",
               seq_bad(), mon_cmd.size());
    else passed++;
    for (int i = 1; i < mon_cyc.size(); i++) begin
      total++;
      if (mon_cyc[i] - mon_cyc[i-1] != 3)
        $display("FAIL basic_spacing idx %0d gap=%0d want 3",
                 i, mon_cyc[i] - mon_cyc[i-1]);
      else passed++;
    end
    pulse_done();
    total++;
    if (issued_cnt !== 6'd4 || finished !== 1 || err !== 0)
      $display("FAIL basic_end cnt=%0d fin=%b err=%b want 4 1 0",
               issued_cnt, finished, err);
    else passed++;
  endtask

  task automatic test_load_stall();
    bit ok;
    int fall;
    int early;
    load_rom('{7, 0});
    build_exp();
    busy = 1;
    pulse_start();
    repeat (68) @(posedge clk);
    early = mon_cmd.size();
    @(posedge clk); #1 busy = 0;
    fall = cyc;
    run_to_write(100, 0, ok);
    total++;
    if (early != 0 || viol != 0)
      $display("FAIL stall_early strobes=%0d viol=%0d want 0",
               early, viol);
    else passed++;
    total++;
    if (!ok || mon_cyc[0] != fall || mon_cmd[0] != 7)
      $display("FAIL stall_first cyc=%0d cmd=%0d want %0d 7",
               ok ? mon_cyc[0] : -1, ok ? mon_cmd[0] : -1, fall);
    else passed++;
    total++;
    if (seq_bad() != -1)
      $display("FAIL stall_seq got %0d cmds want 2",
               mon_cmd.size());
    else passed++;
    pulse_done();
  endtask

  task automatic test_invalid();
    bit ok;
    load_rom('{13, 2, 0});
    build_exp();
    pulse_start();
    total++;
    if (err !== 0 || finished !== 0)
      $display("FAIL restart_clear err=%b fin=%b want 0 0",
               err, finished);
    else passed++;
    run_to_write(100, 0, ok);
    pulse_done();
    total++;
    if (!ok || seq_bad() != -1)
      $display("FAIL invalid_seq got %0d cmds want 2",
               mon_cmd.size());
    else passed++;
    total++;
    if (issued_cnt !== 6'd2 || err !== 1'b1)
      $display("FAIL invalid_end cnt=%0d err=%b want 2 1",
               issued_cnt, err);
    else passed++;
  endtask

  task automatic test_missing_write();
    bit ok;
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 4'd3;
    build_exp();
    pulse_start();
    run_to_write(400, 0, ok);
    pulse_done();
    total++;
    if (!ok || seq_bad() != -1)
      $display("FAIL nowrite_seq got %0d cmds want 33",
               mon_cmd.size());
    else passed++;
    for (int i = 1; i < 32 && i < mon_cyc.size(); i++)
      if (mon_cyc[i] - mon_cyc[i-1] != 3) bad++;
    total++;
    if (bad != 0)
      $display("FAIL nowrite_spacing bad gaps=%0d want 0", bad);
    else passed++;
    total++;
    if (mon_cyc.size() < 33 || mon_cyc[32] - mon_cyc[31] != 1)
      $display("FAIL nowrite_forced gap=%0d want 1",
               mon_cyc.size() < 33 ? -1 : mon_cyc[32] - mon_cyc[31]);
    else passed++;
    total++;
    if (issued_cnt !== 6'd33 || err !== 1'b1)
      $display("FAIL nowrite_end cnt=%0d err=%b want 33 1",
               issued_cnt, err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    load_rom('{4, 1, 5, 0});
    build_exp();
    pulse_start();
    for (int i = 0; i < 20 && mon_cmd.size() == 0; i++)
      @(negedge clk);
    #1;
    @(posedge clk); #1 busy = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (issued_cnt !== 6'd1)
      $display("FAIL mid_pre cnt=%0d want 1", issued_cnt);
    else passed++;
    n = mon_cmd.size();
    reset = 0;
    busy = 0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    total++;
    if (mon_cmd.size() != n)
      $display("FAIL mid_abort strobes=%0d want %0d",
               mon_cmd.size(), n);
    else passed++;
    total++;
    if (bus.cmd_valid !== 0 || bus.CROM_rd !== 0 ||
        finished !== 0 || issued_cnt !== 6'd0)
      $display("FAIL mid_state v=%b rd=%b fin=%b cnt=%0d want 0",
               bus.cmd_valid, bus.CROM_rd, finished, issued_cnt);
    else passed++;
    @(posedge clk); #1 reset = 1;
    pulse_start();
    run_to_write(100, 0, ok);
    pulse_done();
    total++;
    if (!ok || seq_bad() != -1 || issued_cnt !== 6'd4)
      $display("FAIL mid_rerun cmds=%0d cnt=%0d want 4 4",
               mon_cmd.size(), issued_cnt);
    else passed++;
  endtask

  task automatic test_start_ignored();
    bit ok;
    load_rom('{1, 0});
    build_exp();
    pulse_start();
    @(posedge clk); #1 begin start = 1; done = 1; end
    @(posedge clk); #1 begin start = 0; done = 0; end
    run_to_write(100, 0, ok);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (finished !== 1'b0)
      $display("FAIL early_done fin=%b want 0", finished);
    else passed++;
    pulse_done();
    total++;
    if (!ok || seq_bad() != -1 || finished !== 1'b1)
      $display("FAIL ignored_seq cmds=%0d fin=%b want 2 1",
               mon_cmd.size(), finished);
    else passed++;
    total++;
    if (issued_cnt !== 6'd2)
      $display("FAIL ignored_cnt cnt=%0d want 2", issued_cnt);
    else passed++;
  endtask

  task automatic test_random();
    bit ok;
    int r;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 99);
        if (r < 4)       rom[i] = 4'd0;
        else if (r < 22) rom[i] = 4'($urandom_range(12, 15));
        else             rom[i] = 4'($urandom_range(1, 11));
      end
      build_exp();
      pulse_start();
      run_to_write(2000, 1, ok);
      pulse_done();
      total++;
      if (!ok || seq_bad() != -1)
        $display("FAIL rand%0d_seq bad=%0d cmds=%0d want %0d",
                 t, seq_bad(), mon_cmd.size(), exp_q.size());
      else passed++;
      total++;
      if (int'(issued_cnt) != exp_q.size() || err !== exp_err)
        $display("FAIL rand%0d_end cnt=%0d err=%b want %0d %b",
                 t, issued_cnt, err, exp_q.size(), exp_err);
      else passed++;
      total++;
      if (viol != 0 || finished !== 1'b1)
        $display("FAIL rand%0d_busy viol=%0d fin=%b want 0 1",
                 t, viol, finished);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_stall();
    test_invalid();
    test_missing_write();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
